// File: rtl/szamologep_pkg.sv
// ---------------------------------------------------------------------------
// szamologep_pkg
// Shared constants and the opcode enumeration for the szamologep calculator.
//   DATA_W : operand / result / display width (8)
//   OP_W   : opcode width (4)
//   op_e   : ALU opcodes OP_ADD .. OP_SHR; codes 8-15 are unused and yield 0.
// ---------------------------------------------------------------------------
package szamologep_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7
    } op_e;

    // Button bit positions within btn.
    localparam int BTN_EXEC  = 0;
    localparam int BTN_LOADB = 1;
    localparam int BTN_LOADO = 2;
    localparam int BTN_LOADA = 3;

endpackage : szamologep_pkg

// File: rtl/szamologep_alu.sv
// ---------------------------------------------------------------------------
// szamologep_alu
// Purely combinational 8-bit ALU. All results wrap to DATA_W bits.
// Ports:
//   op [3:0] : opcode (see szamologep_pkg::op_e); 8-15 give 0
//   a  [7:0] : operand A
//   b  [7:0] : operand B (shifts use only b[2:0])
//   y  [7:0] : result
// Configuration macro: SZAMOLOGEP_MUL_EN -- when defined, opcode 2 is the low
// byte of a*b; when undefined no multiplier is built and opcode 2 gives 0.
// ---------------------------------------------------------------------------
module szamologep_alu
    import szamologep_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        // NOTE: y gets a value before the case so no path leaves it unassigned,
        // which would otherwise infer a latch.
        y = '0;
        case (op)
            OP_ADD: y = a + b;
            OP_SUB: y = a - b;
`ifdef SZAMOLOGEP_MUL_EN
            OP_MUL: y = a * b;          // 8-bit context keeps the low byte
`else
            OP_MUL: y = '0;
`endif
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_SHL: y = a << b[2:0];
            OP_SHR: y = a >> b[2:0];
            default: y = '0;
        endcase
    end

endmodule : szamologep_alu

// File: rtl/szamologep.sv
// ---------------------------------------------------------------------------
// szamologep
// Switch-and-button calculator. Buttons are edge-detected against the
// previous sample; each press loads an operand/opcode or executes the ALU,
// and the result or loaded value is shown on leds.
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-low
//   dip_sw[7:0]: data / opcode switches
//   btn[3:0]   : [3] load A, [2] load op, [1] load B, [0] execute
//   leds[7:0]  : display register (flop output)
// Configuration macro: SZAMOLOGEP_MUL_EN (enables MUL in szamologep_alu).
// ---------------------------------------------------------------------------
module szamologep
    import szamologep_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dip_sw,
    input  logic [3:0]        btn,
    output logic [DATA_W-1:0] leds
);

    logic [DATA_W-1:0] opa_q,  opa_d;
    logic [DATA_W-1:0] opb_q,  opb_d;
    logic [OP_W-1:0]   op_q,   op_d;
    logic [DATA_W-1:0] leds_q, leds_d;
    logic [3:0]        btn_q;
    logic [3:0]        btn_edge;
    logic [DATA_W-1:0] alu_y;

    // A held button only fires once: the event is the low-to-high transition.
    assign btn_edge = btn & ~btn_q;

    // The ALU sees the pre-edge operands, so an execute in the same cycle as
    // a load uses the old values.
    szamologep_alu u_alu (
        .op (op_q),
        .a  (opa_q),
        .b  (opb_q),
        .y  (alu_y)
    );

    always_comb begin
        opa_d  = opa_q;
        opb_d  = opb_q;
        op_d   = op_q;
        leds_d = leds_q;

        // Every simultaneous load is taken.
        if (btn_edge[BTN_LOADA]) opa_d = dip_sw;
        if (btn_edge[BTN_LOADO]) op_d  = dip_sw[OP_W-1:0];
        if (btn_edge[BTN_LOADB]) opb_d = dip_sw;

        // The display shows one source; execute wins, load A loses.
        if (btn_edge[BTN_EXEC])
            leds_d = alu_y;
        else if (btn_edge[BTN_LOADB])
            leds_d = dip_sw;
        else if (btn_edge[BTN_LOADO])
            leds_d = {{(DATA_W-OP_W){1'b0}}, dip_sw[OP_W-1:0]};
        else if (btn_edge[BTN_LOADA])
            leds_d = dip_sw;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            opa_q  <= '0;
            opb_q  <= '0;
            op_q   <= '0;
            leds_q <= '0;
        end else begin
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            op_q   <= op_d;
            leds_q <= leds_d;
        end
        // Tracking btn through reset means a button held across release is
        // already "seen" and does not fire.
        btn_q <= btn;
    end

    assign leds = leds_q;

endmodule : szamologep

// File: tb/tb_szamologep.sv
// ---------------------------------------------------------------------------
// tb_szamologep
// Self-checking bench for szamologep. Expected display values are pushed to a
// scoreboard queue when the stimulus is applied and popped when leds is
// sampled (on the falling clock edge, half a cycle after the active edge).
// Honours SZAMOLOGEP_MUL_EN for the expected MUL result.
// ---------------------------------------------------------------------------
module tb_szamologep;

    logic       clk;
    logic       reset;
    logic [7:0] dip_sw;
    logic [3:0] btn;
    logic [7:0] leds;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Bench-side copy of the architectural registers for the random section.
    logic [7:0] m_a, m_b;
    logic [3:0] m_op;

    szamologep dut (
        .clk    (clk),
        .reset  (reset),
        .dip_sw (dip_sw),
        .btn    (btn),
        .leds   (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [3:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        logic [15:0] prod;
        logic [15:0] wide;
        case (op)
            4'd0: alu_ref = 8'((16'(a) + 16'(b)) % 256);
            4'd1: alu_ref = 8'((16'(a) + 16'd256 - 16'(b)) % 256);
`ifdef SZAMOLOGEP_MUL_EN
            4'd2: begin prod = 16'(a) * 16'(b); alu_ref = prod[7:0]; end
`else
            4'd2: alu_ref = 8'h00;
`endif
            4'd3: alu_ref = a & b;
            4'd4: alu_ref = a | b;
            4'd5: alu_ref = a ^ b;
            4'd6: begin wide = 16'(a) * (16'd1 << b[2:0]); alu_ref = wide[7:0]; end
            4'd7: alu_ref = 8'(a / (8'd1 << b[2:0]));
            default: alu_ref = 8'h00;
        endcase
    endfunction

    task automatic expect_val(input logic [7:0] v, input string tag);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed leds=%h, no expected value", leds);
        end else begin
            e = sb.pop_front();
            assert (leds === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed leds=%h expected %h", e.tag, leds, e.val);
            end
        end
    endtask

    // One-cycle button pulse, then release and compare.
    task automatic press(input logic [3:0] b, input logic [7:0] sw,
                         input logic [7:0] exp_v, input string tag);
        @(negedge clk);
        btn    = b;
        dip_sw = sw;
        expect_val(exp_v, tag);
        @(negedge clk);
        btn = 4'b0000;
        check_out();
    endtask

    task automatic load_a(input logic [7:0] v);
        press(4'b1000, v, v, "load_a");
        m_a = v;
    endtask

    task automatic load_op(input logic [3:0] v);
        press(4'b0100, {4'h0, v}, {4'h0, v}, "load_op");
        m_op = v;
    endtask

    task automatic load_b(input logic [7:0] v);
        press(4'b0010, v, v, "load_b");
        m_b = v;
    endtask

    task automatic exec(input logic [7:0] exp_v, input string tag);
        press(4'b0001, 8'h00, exp_v, tag);
    endtask

    initial begin
        logic [7:0] mul_exp;

        reset  = 1'b0;
        btn    = 4'b0000;
        dip_sw = 8'h00;
        m_a = 8'h00; m_b = 8'h00; m_op = 4'h0;

        // ---- Reset with random inputs ----
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            btn    = 4'($urandom);
            dip_sw = 8'($urandom);
            expect_val(8'h00, "reset_hold");
            @(negedge clk);
            check_out();
        end
        btn   = 4'b0000;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expect_val(8'h00, "reset_release");
            @(negedge clk);
            check_out();
        end

        // ---- Basic sequence ----
        load_a(8'd15);
        load_op(4'd1);
        load_b(8'd3);
        exec(8'h0C, "seq_sub");

        // ---- Wrap-around ----
        load_a(8'd3);   load_op(4'd1); load_b(8'd15);
        exec(8'hF4, "wrap_sub");
        load_a(8'd200); load_op(4'd0); load_b(8'd100);
        exec(8'h2C, "wrap_add");
`ifdef SZAMOLOGEP_MUL_EN
        mul_exp = 8'h10;
`else
        mul_exp = 8'h00;
`endif
        load_a(8'd16);  load_op(4'd2); load_b(8'd17);
        exec(mul_exp, "wrap_mul");

        // ---- Shifts and unused opcode ----
        load_a(8'h81); load_b(8'h09);
        load_op(4'd6); exec(8'h02, "shl");
        load_op(4'd7); exec(8'h40, "shr");
        load_op(4'd9); exec(8'h00, "op9");

        // ---- Held execute with an A reload in the middle ----
        load_a(8'h10); load_op(4'd0); load_b(8'h01);
        @(negedge clk);
        btn = 4'b0001;
        expect_val(8'h11, "held_first");
        @(negedge clk);
        check_out();
        for (int i = 1; i < 20; i++) begin
            if (i == 5) begin
                btn    = 4'b1001;
                dip_sw = 8'h20;
            end else begin
                btn = 4'b0001;
            end
            expect_val((i < 5) ? 8'h11 : 8'h20, "held_no_repeat");
            @(negedge clk);
            check_out();
        end
        btn = 4'b0000;
        m_a = 8'h20;
        exec(8'h21, "held_repress");

        // ---- Simultaneous execute + load A ----
        load_a(8'd5); load_op(4'd0); load_b(8'd2);
        press(4'b1001, 8'h30, 8'h07, "simul_exec_wins");
        exec(8'h32, "simul_opa_loaded");

        // ---- Load priority: B display beats op and A ----
        press(4'b1110, 8'h9C, 8'h9C, "simul_load_prio");
        m_a = 8'h9C; m_op = 4'hC; m_b = 8'h9C;
        exec(8'h00, "simul_all_loaded");

        // ---- Random operations against the bench model ----
        for (int i = 0; i < 12; i++) begin
            load_a(8'($urandom));
            load_b(8'($urandom));
            load_op(4'($urandom_range(0, 9)));
            exec(alu_ref(m_op, m_a, m_b), "random_op");
        end

        // ---- Idle cycles: display holds ----
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dip_sw = 8'($urandom);
            expect_val(alu_ref(m_op, m_a, m_b), "idle_hold");
            @(negedge clk);
            check_out();
        end

        // ---- Reset mid-sequence, button held across release ----
        load_a(8'h77); load_b(8'h11);
        @(negedge clk);
        reset  = 1'b0;
        btn    = 4'b1000;
        dip_sw = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            expect_val(8'h00, "reset_mid");
            @(negedge clk);
            check_out();
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_val(8'h00, "held_through_release");
            @(negedge clk);
            check_out();
        end
        btn = 4'b0000;
        exec(8'h00, "exec_after_reset");

        if (sb.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_szamologep

// File: doc/szamologep.md
SZAMOLOGEP -- requirements
Module: szamologep

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are named clk and reset as in the rest of the codebase.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous active-low reset (0 = reset asserted).
REQ-004 dip_sw  input  8  data/opcode entry switches.
REQ-005 btn  input  4  command buttons, active-high level: btn[3] load A, btn[2] load op, btn[1] load B, btn[0] execute.
REQ-006 leds  output  8  display register, driven directly from a flop.

Function
REQ-007 Registers SHALL be: opA[7:0], opB[7:0], op[3:0], btn_q[3:0] (previous btn sample), leds[7:0].
REQ-008 A button event SHALL be a rising edge, edge[i] = btn[i] & ~btn_q[i]; a held button SHALL produce exactly one event; btn_q <= btn every cycle.
REQ-009 On the clock edge where edge[3]=1: opA <= dip_sw and leds <= dip_sw.
REQ-010 On edge[2]: op <= dip_sw[3:0] and leds <= {4'b0, dip_sw[3:0]}.
REQ-011 On edge[1]: opB <= dip_sw and leds <= dip_sw.
REQ-012 On edge[0]: leds <= ALU(op, opA, opB), using the register values held before this clock edge.
REQ-013 Latency: leds SHALL update on the first rising clk edge at which the button is sampled high while btn_q is low (one-cycle response).
REQ-014 Opcodes, 8-bit unsigned, result truncated to 8 bits (wrap-around): 0 ADD, 1 SUB (A-B), 2 MUL (low 8 bits of A*B), 3 AND, 4 OR, 5 XOR, 6 SHL (A << B[2:0]), 7 SHR (A >> B[2:0]); opcodes 8-15 SHALL yield 8'h00.
REQ-015 Simultaneous events: all register loads SHALL happen in the same cycle; leds takes the source with priority btn[0] > btn[1] > btn[2] > btn[3].
REQ-016 No event (all edges 0): all registers except btn_q SHALL hold.

Reset
REQ-017 While reset=0 at a clock edge: opA, opB, op, leds <= 0; btn_q <= btn, so a button held through reset release SHALL NOT generate an event.
REQ-018 Reset asserted mid-sequence SHALL discard loaded operands; execute after reset with no loads SHALL yield ADD(0,0) = 8'h00.

Configuration
REQ-019 Macro SZAMOLOGEP_MUL_EN: when defined, opcode 2 SHALL be the MUL of REQ-014; when undefined, no multiplier SHALL be synthesized and opcode 2 SHALL yield 8'h00.

Structure
REQ-020 Package szamologep_pkg SHALL hold the data width constant (8), opcode width (4) and the opcode enumeration (OP_ADD .. OP_SHR).
REQ-021 The ALU SHALL be a purely combinational sub-module szamologep_alu (inputs op, a, b; output y); edge detection, registers and display mux stay in szamologep.

Verification
REQ-022 Reset: reset=0 for 10 cycles with random dip_sw/btn -> leds=8'h00; release with btn=0 -> leds stays 8'h00.
REQ-023 Sequence: dip_sw=15, btn=8 -> leds=8'h0F; dip_sw=1, btn=4 -> leds=8'h01; dip_sw=3, btn=2 -> leds=8'h03; btn=1 -> leds=8'h0C.
REQ-024 Wrap: A=3, op=1, B=15, execute -> leds=8'hF4; A=200, op=0, B=100 -> leds=8'h2C; A=16, op=2, B=17 -> leds=8'h10 (MUL_EN defined) or 8'h00 (undefined).
REQ-025 Held button: btn=1 held 20 cycles while opA is reloaded via a separate btn[3] pulse -> leds does not recompute until btn[0] is released and pressed again.
REQ-026 Simultaneous: btn=4'b1001 in one cycle with A=5, op=0, B=2 previously loaded -> leds=8'h07 and opA updated to dip_sw.
REQ-027 Opcodes 6, 7 and 9: A=8'h81, B=8'h09 -> SHL gives 8'h02, SHR gives 8'h40, op=9 gives 8'h00.
